// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding command-to-APB master bridge.
// Optional ACCESS wait-state timeout: define APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        P_clk,
    input  logic        P_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] P_addr,
    output logic        P_selx,
    output logic        P_enable,
    output logic        P_write,
    output logic [31:0] P_wdata,
    input  logic        P_ready,
    input  logic        P_slverr,
    input  logic [31:0] P_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t      r_state;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_addr;
    logic        r_selx;
    logic        r_enable;
    logic        r_write;
    logic [31:0] r_wdata;
    logic        w_accept;

    assign w_accept = (r_state == IDLE) && cmd_valid && r_cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_wait_cnt;
    logic          w_timeout;

    // Limit hit on the cycle that would make the count reach TIMEOUT_CYCLES
    assign w_timeout = (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge P_clk) begin
        if (P_rst) begin
            r_wait_cnt <= '0;
        end else if (w_accept) begin
            r_wait_cnt <= '0;
        end else if (r_state == ACCESS && !P_ready) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge P_clk) begin
        if (P_rst) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_addr      <= '0;
            r_selx      <= 1'b0;
            r_enable    <= 1'b0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state     <= SETUP;
                        r_cmd_ready <= 1'b0;
                        r_selx      <= 1'b1;
                        r_addr      <= cmd_addr;
                        r_write     <= cmd_write;
                        r_wdata     <= cmd_wdata;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    r_state  <= ACCESS;
                    r_enable <= 1'b1;
                end
                ACCESS: begin
                    if (P_ready) begin
                        r_state     <= RESP;
                        r_selx      <= 1'b0;
                        r_enable    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= P_slverr;
                        r_rsp_rdata <= r_write ? 32'h0 : P_rdata;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_state     <= RESP;
                        r_selx      <= 1'b0;
                        r_enable    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign P_addr    = r_addr;
    assign P_selx    = r_selx;
    assign P_enable  = r_enable;
    assign P_write   = r_write;
    assign P_wdata   = r_wdata;

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, maximum ACCESS-phase wait cycles before abort (used only with APB_MASTER_TIMEOUT_EN).
REQ-002 SHALL have ports:
- P_clk  input  1  single clock; all logic on rising edge.
- P_rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  bridge accepts a command.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  32  transfer address.
- cmd_wdata  input  32  write data.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed.
- rsp_rdata  output  32  read data; 0 for writes.
- rsp_err  output  1  slave error or timeout.
- P_addr  output  32  APB address.
- P_selx  output  1  APB select.
- P_enable  output  1  APB enable.
- P_write  output  1  APB direction.
- P_wdata  output  32  APB write data.
- P_ready  input  1  APB slave ready.
- P_slverr  input  1  APB slave error.
- P_rdata  input  32  APB read data.

Function
REQ-003 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; all outputs driven from registers.
REQ-004 IDLE: cmd_ready=1, P_selx=0, P_enable=0; on cmd_valid&cmd_ready, capture cmd_write/cmd_addr/cmd_wdata into P_write/P_addr/P_wdata and go to SETUP next cycle.
REQ-005 SETUP: exactly one cycle with P_selx=1, P_enable=0; P_ready ignored; unconditionally go to ACCESS.
REQ-006 ACCESS: P_selx=1, P_enable=1; remain while P_ready=0; on P_ready=1 sample P_slverr into rsp_err and, for reads, P_rdata into rsp_rdata (writes load 0), then go to RESP with P_selx=P_enable=0.
REQ-007 P_addr, P_write, P_wdata SHALL remain stable from SETUP through the final ACCESS cycle; they SHALL retain last values otherwise.
REQ-008 RESP: rsp_valid=1, cmd_ready=0; rsp_rdata/rsp_err held stable; on rsp_ready=1 go to IDLE; rsp_valid low next cycle.
REQ-009 cmd_ready SHALL be 0 in SETUP, ACCESS and RESP; only one transfer outstanding.
REQ-010 Minimum latency: command accept edge -> rsp_valid high after 3 edges (SETUP, ACCESS with P_ready=1, RESP); each extra wait cycle adds one.
REQ-011 rsp_ready asserted while rsp_valid=0 SHALL have no effect.
REQ-012 Back-to-back: a command held on cmd_valid during RESP SHALL be accepted in the IDLE cycle following the rsp_ready handshake.

Reset
REQ-013 On P_rst=1 at an edge: state=IDLE, P_selx=0, P_enable=0, P_write=0, P_addr=0, P_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cmd_ready=0 during reset cycle, 1 in the first cycle after release.
REQ-014 Reset mid-transfer (SETUP/ACCESS/RESP) SHALL abort it: APB strobes low after that edge, pending response discarded, no rsp_valid issued.

Configuration
REQ-015 Macro APB_MASTER_TIMEOUT_EN: when defined, a counter cleared on SETUP entry increments per ACCESS cycle with P_ready=0; on reaching TIMEOUT_CYCLES the bridge SHALL drop P_selx/P_enable, load rsp_err=1, rsp_rdata=0, and go to RESP; P_ready arriving in the same cycle as the limit SHALL win (normal completion).
REQ-016 When APB_MASTER_TIMEOUT_EN is undefined, ACCESS SHALL wait indefinitely and no counter logic SHALL exist.

Verification
REQ-017 Write cmd addr=0x04 wdata=0xDEADBEEF, P_ready=1 in first ACCESS -> SETUP then ACCESS with stable P_addr=0x04, P_write=1; rsp_valid 3 edges after accept, rsp_err=0, rsp_rdata=0.
REQ-018 Read addr=0x04, slave returns P_rdata=0xDEADBEEF after 2 wait cycles -> P_enable high 3 cycles, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-019 Read with P_slverr=1 at P_ready -> rsp_err=1; rsp_rdata=P_rdata; rsp_valid held 4 cycles until rsp_ready=1, then IDLE.
REQ-020 P_rst pulsed during ACCESS -> next cycle P_selx=0, P_enable=0, rsp_valid never asserts; next command completes normally.
REQ-021 With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, P_ready held 0 -> after 16 ACCESS cycles strobes drop, rsp_err=1, rsp_rdata=0.
REQ-022 Two commands with cmd_valid held continuously, rsp_ready=1 -> second accepted the cycle after first response handshake; no overlap of P_selx periods.
